// File: rtl/if_id_skid_pkg.sv
// if_id_skid_pkg: shared pipeline constants (NOP encoding, zero word, interrupt-none, hold flag levels).
package if_id_skid_pkg;
  localparam logic [31:0] INST_NOP = 32'h00000013;
  localparam logic [31:0] ZERO_WORD = 32'h00000000;
  localparam logic [7:0] INT_NONE = 8'h00;
  localparam int HOLD_FLAG_W = 3;
  typedef enum logic [HOLD_FLAG_W-1:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3
  } hold_flag_e;
endpackage

// File: rtl/if_id_skid_buf.sv
// skid_buf: generic WIDTH-bit 2-entry valid/ready skid buffer with flush; ready_o is purely registered.
module skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);
  logic o_v, s_v, accept, drain;
  logic [WIDTH-1:0] o_d, s_d;
  assign ready_o = ~s_v;
  assign accept  = valid_i & ~s_v;
  assign drain   = o_v & ready_i;
  assign valid_o = o_v;
  assign data_o  = o_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      o_v <= 1'b0;
      s_v <= 1'b0;
      o_d <= '0;
      s_d <= '0;
    end else if (flush_i) begin
      o_v <= 1'b0;
      s_v <= 1'b0;
    end else if (!o_v || drain) begin
      if (s_v) begin
        o_d <= s_d;
        o_v <= 1'b1;
        s_v <= 1'b0;
      end else if (accept) begin
        o_d <= data_i;
        o_v <= 1'b1;
      end else
        o_v <= 1'b0;
    end else if (accept) begin
      s_d <= data_i;
      s_v <= 1'b1;
    end
endmodule

// File: rtl/if_id_skid.sv
// if_id_skid: IF/ID stage register with valid/ready skid, flush and legacy hold gating.
// Optional IF_ID_SKID_PERF_EN adds saturating stall/flush counters.
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int INST_W = 32,
  parameter int ADDR_W = 32,
  parameter int INT_W  = 8,
  parameter logic [INST_W-1:0] NOP_VAL = INST_W'(INST_NOP),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [2:0]        hold_flag_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic [INT_W-1:0]  int_flag_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [INT_W-1:0]  int_flag_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);
  localparam int W = INT_W + ADDR_W + INST_W;
  logic hold, rdy_eff;
  logic [W-1:0] data;
  assign hold    = hold_flag_i >= HOLD_IF;
  assign rdy_eff = ready_i & ~hold;
  skid_buf #(.WIDTH(W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  ({int_flag_i, inst_addr_i, inst_i}),
    .valid_o (valid_o),
    .ready_i (rdy_eff),
    .data_o  (data)
  );
  // Stale payload stays in the flops; an empty stage must look like a NOP bubble.
  assign inst_o      = valid_o ? data[INST_W-1:0] : NOP_VAL;
  assign inst_addr_o = valid_o ? data[INST_W +: ADDR_W] : ADDR_W'(ZERO_WORD);
  assign int_flag_o  = valid_o ? data[W-1 -: INT_W] : INT_W'(INT_NONE);
`ifdef IF_ID_SKID_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (valid_o && !rdy_eff && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_i && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_if_id_skid.sv
// tb_if_id_skid: randomized and directed checks of if_id_skid against a queue-based reference model.
module tb_if_id_skid;
`ifdef IF_ID_SKID_PERF_EN
  localparam int CNT_W = 4;
  localparam bit PERF = 1'b1;
`else
  localparam int CNT_W = 16;
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0, rst, flush_i, valid_i, ready_i, ready_o, valid_o;
  logic [2:0] hold_flag_i;
  logic [31:0] inst_i, inst_addr_i, inst_o, inst_addr_o;
  logic [7:0] int_flag_i, int_flag_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [7:0]  intf;
  } beat_t;
  beat_t q[$];
  logic [CNT_W-1:0] stall_m, flush_m;
  int vectors = 0, errors = 0;

  if_id_skid #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .hold_flag_i(hold_flag_i),
    .valid_i(valid_i), .ready_o(ready_o), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .int_flag_i(int_flag_i), .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o),
    .inst_addr_o(inst_addr_o), .int_flag_o(int_flag_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] e_inst();
    return q.size() > 0 ? q[0].inst : NOP;
  endfunction
  function automatic logic [31:0] e_addr();
    return q.size() > 0 ? q[0].addr : 32'h0;
  endfunction
  function automatic logic [7:0] e_int();
    return q.size() > 0 ? q[0].intf : 8'h0;
  endfunction
  function automatic logic [CNT_W-1:0] e_stall();
    return PERF ? stall_m : '0;
  endfunction
  function automatic logic [CNT_W-1:0] e_flush();
    return PERF ? flush_m : '0;
  endfunction

  // Stage modelled as a FIFO of at most two beats; flush empties it.
  task automatic tick();
    bit rdy, acc, drn;
    @(posedge clk);
    rdy = ready_i && (hold_flag_i < 3'd2);
    acc = valid_i && q.size() < 2;
    drn = q.size() > 0 && rdy;
    if (q.size() > 0 && !rdy && stall_m != '1) stall_m = stall_m + 1'b1;
    if (flush_i && flush_m != '1) flush_m = flush_m + 1'b1;
    if (flush_i) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back('{inst_i, inst_addr_i, int_flag_i});
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] addr, input logic [7:0] intf);
    valid_i = v;
    inst_i = inst;
    inst_addr_i = addr;
    int_flag_i = intf;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    q.delete();
    stall_m = '0;
    flush_m = '0;
    flush_i = 1'b0;
    hold_flag_i = 3'd0;
    ready_i = 1'b0;
    drive(1'b0, 32'hdeadbeef, 32'hdeadbeef, 8'hff);
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    vectors++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || inst_o !== NOP || inst_addr_o !== 32'h0 || int_flag_o !== 8'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b ready=%b inst=%h addr=%h int=%h, want 0 1 %h 0 0", valid_o, ready_o, inst_o, inst_addr_o, int_flag_o, NOP);
    end
    vectors++;
    if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_counters: stall=%0d flush=%0d, want 0 0", stall_cnt_o, flush_cnt_o);
    end
    do_reset();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    ready_i = 1'b0;
    drive(1'b1, 32'h00100093, 32'h0, 8'h1);
    tick();
    drive(1'b1, 32'h00200113, 32'h4, 8'h2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    vectors++;
    if (valid_o !== 1'b1 || ready_o !== 1'b0 || inst_o !== 32'h00100093) begin
      errors++;
      $display("FAIL midstream_fill: valid=%b ready=%b inst=%h, want 1 0 00100093", valid_o, ready_o, inst_o);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || inst_o !== NOP || inst_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b ready=%b inst=%h addr=%h, want 0 1 %h 0", valid_o, ready_o, inst_o, inst_addr_o, NOP);
    end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h00000093 | (32'(i) << 20), 32'(i * 4), 8'(i));
      tick();
      vectors++;
      if (valid_o !== 1'b1 || inst_addr_o !== 32'(i * 4) || inst_o !== e_inst() || int_flag_o !== 8'(i)) begin
        errors++;
        $display("FAIL stream_%0d: valid=%b addr=%h inst=%h int=%h, want 1 %h %h %h", i, valid_o, inst_addr_o, inst_o, int_flag_o, i * 4, e_inst(), i);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    tick();
    vectors++;
    if (valid_o !== 1'b0 || inst_o !== NOP) begin
      errors++;
      $display("FAIL stream_end: valid=%b inst=%h, want 0 %h", valid_o, inst_o, NOP);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready_i = 1'b0;
    drive(1'b1, 32'haaaa0013, 32'h0, 8'h0a);
    tick();
    drive(1'b1, 32'hbbbb0013, 32'h4, 8'h0b);
    tick();
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    vectors++;
    if (valid_o !== 1'b1 || inst_o !== 32'haaaa0013 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: valid=%b inst=%h ready=%b, want 1 aaaa0013 0", valid_o, inst_o, ready_o);
    end
    ready_i = 1'b1;
    tick();
    vectors++;
    if (valid_o !== 1'b1 || inst_o !== 32'hbbbb0013 || inst_addr_o !== 32'h4 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: valid=%b inst=%h addr=%h ready=%b, want 1 bbbb0013 4 1", valid_o, inst_o, inst_addr_o, ready_o);
    end
    tick();
    vectors++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_drained: valid=%b, want 0", valid_o);
    end
  endtask

  task automatic test_flush();
    do_reset();
    ready_i = 1'b0;
    drive(1'b1, 32'haaaa0013, 32'h0, 8'h0);
    tick();
    drive(1'b1, 32'hbbbb0013, 32'h4, 8'h0);
    tick();
    drive(1'b1, 32'hcccc0013, 32'h8, 8'h0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    vectors++;
    if (valid_o !== 1'b0 || inst_o !== NOP || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: valid=%b inst=%h ready=%b, want 0 %h 1", valid_o, inst_o, ready_o, NOP);
    end
    ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost_%0d: valid=%b inst=%h, want 0", i, valid_o, inst_o);
      end
    end
  endtask

  task automatic test_hold();
    do_reset();
    ready_i = 1'b1;
    drive(1'b1, 32'h00300193, 32'hc, 8'h3);
    tick();
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    hold_flag_i = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (valid_o !== 1'b1 || inst_o !== 32'h00300193 || inst_addr_o !== 32'hc) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b inst=%h addr=%h, want 1 00300193 c", i, valid_o, inst_o, inst_addr_o);
      end
    end
    vectors++;
    if (stall_cnt_o !== (PERF ? CNT_W'(3) : '0)) begin
      errors++;
      $display("FAIL hold_stall_cnt: got %0d want %0d", stall_cnt_o, PERF ? 3 : 0);
    end
    hold_flag_i = 3'd0;
    tick();
    vectors++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: valid=%b, want 0", valid_o);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    flush_i = 1'b1;
    repeat (20) tick();
    flush_i = 1'b0;
    vectors++;
    if (flush_cnt_o !== (PERF ? CNT_W'(20 < (1 << CNT_W) - 1 ? 20 : (1 << CNT_W) - 1) : '0)) begin
      errors++;
      $display("FAIL flush_sat: got %0d want %0d", flush_cnt_o, PERF ? 15 : 0);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom, $urandom, 8'($urandom));
      ready_i = $urandom_range(0, 9) < 6;
      hold_flag_i = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      flush_i = $urandom_range(0, 19) == 0;
      tick();
      vectors++;
      if (valid_o !== (q.size() > 0) || ready_o !== (q.size() < 2)) begin
        errors++;
        $display("FAIL rand_hs_%0d: valid=%b ready=%b, want %b %b", i, valid_o, ready_o, q.size() > 0, q.size() < 2);
      end
      vectors++;
      if (inst_o !== e_inst() || inst_addr_o !== e_addr() || int_flag_o !== e_int()) begin
        errors++;
        $display("FAIL rand_data_%0d: inst=%h addr=%h int=%h, want %h %h %h", i, inst_o, inst_addr_o, int_flag_o, e_inst(), e_addr(), e_int());
      end
      vectors++;
      if (stall_cnt_o !== e_stall() || flush_cnt_o !== e_flush()) begin
        errors++;
        $display("FAIL rand_cnt_%0d: stall=%0d flush=%0d, want %0d %0d", i, stall_cnt_o, flush_cnt_o, e_stall(), e_flush());
      end
    end
    flush_i = 1'b0;
  endtask

  initial begin
    flush_i = 1'b0;
    ready_i = 1'b0;
    hold_flag_i = 3'd0;
    stall_m = '0;
    flush_m = '0;
    drive(1'b0, 32'h0, 32'h0, 8'h0);
    test_reset();
    test_reset_midstream();
    test_stream();
    test_backpressure();
    test_flush();
    test_hold();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
